// File: rtl/led_pkg.sv
// Shared constants, types and helpers for the zone statistics blocks.
package led_pkg;

  localparam int ZONE_COLS = 24;
  localparam int ZONE_ROWS = 15;
  localparam int NUM_ZONES = ZONE_COLS * ZONE_ROWS;
  localparam int GRAY_W    = 8;
  localparam int ADDR_W    = 9;

  typedef logic [GRAY_W-1:0] gray_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } emit_state_e;

  function automatic gray_t max3(input gray_t a, input gray_t b, input gray_t c);
    gray_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/zone_emitter.sv
// Shadow bank and band emitter: streams one band of zone maxima to the gray
// buffer, one entry per cycle, restarting whenever a new band copy lands.
//
// state   | meaning
// ST_IDLE | no band pending, outputs hold their last written values
// ST_EMIT | writing shadow[k] to address base+k, k = 0..N_COLS-1
module zone_emitter
  import led_pkg::*;
#(
  parameter int N_COLS = ZONE_COLS,
  parameter int N_ROWS = ZONE_ROWS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          copy_en,
  input  logic [N_COLS-1:0][GRAY_W-1:0] copy_data,
  input  addr_t                         copy_base,
  output logic                          buf_en,
  output addr_t                         cnt_buf,
  output gray_t                         gray,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int          KW        = $clog2(N_COLS + 1);
  localparam logic [KW-1:0] K_LAST  = KW'(N_COLS - 1);
  localparam addr_t       LAST_ADDR = ADDR_W'(N_COLS * N_ROWS - 1);

  emit_state_e                   state, state_nxt;
  logic [KW-1:0]                 k, k_nxt;
  logic [N_COLS-1:0][GRAY_W-1:0] shadow;
  addr_t                         base;
  addr_t                         addr_cur, addr_hold;
  gray_t                         gray_cur, gray_hold;
  logic                          emitting;

  assign emitting = (state == ST_EMIT);
  assign addr_cur = base + ADDR_W'(k);
  assign gray_cur = shadow[k];

  // A copy always restarts the sweep at k=0, whether idle or mid-band.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      ST_IDLE: begin
        if (copy_en) begin
          state_nxt = ST_EMIT;
          k_nxt     = '0;
        end
      end
      ST_EMIT: begin
        if (copy_en) begin
          k_nxt = '0;
        end else if (k == K_LAST) begin
          state_nxt = ST_IDLE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      k          <= '0;
      shadow     <= '0;
      base       <= '0;
      addr_hold  <= '0;
      gray_hold  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (copy_en) begin
        shadow <= copy_data;
        base   <= copy_base;
      end
      if (emitting) begin
        addr_hold <= addr_cur;
        gray_hold <= gray_cur;
      end
      frame_done <= emitting && (addr_cur == LAST_ADDR);
      overrun    <= copy_en && emitting;
    end
  end

  // Write port is driven straight from the live sweep; between sweeps the
  // last written address/data stay visible.
  assign buf_en  = emitting;
  assign cnt_buf = emitting ? addr_cur : addr_hold;
  assign gray    = emitting ? gray_cur : gray_hold;

endmodule

// File: rtl/zone_max_gray.sv
// Per-zone maximum gray (max of R,G,B) over a video frame, emitted one band of
// zones at a time into a 360-entry gray buffer.
module zone_max_gray #(
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int ZONE_COLS = led_pkg::ZONE_COLS,
  parameter int ZONE_ROWS = led_pkg::ZONE_ROWS
) (
  input  logic                        I_pix_clk,
  input  logic                        I_rst_n,
  input  logic                        I_vs,
  input  logic                        I_de,
  input  logic [led_pkg::GRAY_W-1:0]  I_data_r,
  input  logic [led_pkg::GRAY_W-1:0]  I_data_g,
  input  logic [led_pkg::GRAY_W-1:0]  I_data_b,
  output logic                        O_buf_en,
  output logic [led_pkg::ADDR_W-1:0]  O_cnt_buf,
  output logic [led_pkg::GRAY_W-1:0]  O_gray,
  output logic                        O_frame_done,
  output logic                        O_overrun
);
  import led_pkg::*;

  localparam int ZONE_W = H_ACTIVE / ZONE_COLS;
  localparam int ZONE_H = V_ACTIVE / ZONE_ROWS;
  localparam int PW     = $clog2(H_ACTIVE + 1);
  localparam int ZWW    = $clog2(ZONE_W + 1);
  localparam int ZHW    = $clog2(ZONE_H + 1);
  localparam int CW     = $clog2(ZONE_COLS + 1);
  localparam int BW     = $clog2(ZONE_ROWS + 1);

  logic                 vs_d, de_d, armed;
  logic                 vs_rise, line_end, band_live, pix_ok, band_end, copy_en;
  logic [PW-1:0]        pix_cnt;
  logic [ZWW-1:0]       zone_rem;
  logic [CW-1:0]        zone_col;
  logic [ZHW-1:0]       line_in_band;
  logic [BW-1:0]        band;
  addr_t                copy_base;

  gray_t                gray_p1;
  logic                 valid_p1;
  logic [CW-1:0]        col_p1;

  logic [ZONE_COLS-1:0][GRAY_W-1:0] acc, acc_merged;

  // armed stays low after reset until a fresh VS edge, so a partially seen
  // frame never contributes to any band.
  assign vs_rise   = I_vs && !vs_d;
  assign line_end  = armed && de_d && !I_de;
  assign band_live = (band < BW'(ZONE_ROWS));
  assign pix_ok    = armed && I_de && band_live && (pix_cnt < PW'(H_ACTIVE));
  assign band_end  = line_end && band_live && (line_in_band == ZHW'(ZONE_H - 1));
  assign copy_en   = band_end && !vs_rise;
  assign copy_base = ADDR_W'(band * ZONE_COLS);

  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_d  <= 1'b1;
      de_d  <= 1'b0;
      armed <= 1'b0;
    end else begin
      vs_d <= I_vs;
      de_d <= I_de;
      if (vs_rise) armed <= 1'b1;
    end
  end

  // Column position uses a per-zone down-counter; zone_col steps on its
  // terminal count.
  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pix_cnt      <= '0;
      zone_rem     <= '0;
      zone_col     <= '0;
      line_in_band <= '0;
      band         <= '0;
    end else if (vs_rise) begin
      pix_cnt      <= '0;
      zone_rem     <= ZWW'(ZONE_W - 1);
      zone_col     <= '0;
      line_in_band <= '0;
      band         <= '0;
    end else if (line_end) begin
      pix_cnt  <= '0;
      zone_rem <= ZWW'(ZONE_W - 1);
      zone_col <= '0;
      if (band_live) begin
        if (line_in_band == ZHW'(ZONE_H - 1)) begin
          line_in_band <= '0;
          band         <= band + 1'b1;
        end else begin
          line_in_band <= line_in_band + 1'b1;
        end
      end
    end else if (pix_ok) begin
      pix_cnt <= pix_cnt + 1'b1;
      if (zone_rem == '0) begin
        zone_rem <= ZWW'(ZONE_W - 1);
        zone_col <= zone_col + 1'b1;
      end else begin
        zone_rem <= zone_rem - 1'b1;
      end
    end
  end

  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      gray_p1  <= '0;
      valid_p1 <= 1'b0;
      col_p1   <= '0;
    end else begin
      gray_p1  <= max3(I_data_r, I_data_g, I_data_b);
      valid_p1 <= pix_ok && !vs_rise;
      col_p1   <= zone_col;
    end
  end

  // The P1 pixel is folded in before the copy so a band's last pixel,
  // still in flight when DE falls, lands in the shadow bank.
  always_comb begin
    acc_merged = acc;
    if (valid_p1 && (gray_p1 > acc[col_p1])) acc_merged[col_p1] = gray_p1;
  end

  always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      acc <= '0;
    end else if (vs_rise || copy_en) begin
      acc <= '0;
    end else begin
      acc <= acc_merged;
    end
  end

  zone_emitter #(
    .N_COLS (ZONE_COLS),
    .N_ROWS (ZONE_ROWS)
  ) u_emitter (
    .clk        (I_pix_clk),
    .rst_n      (I_rst_n),
    .copy_en    (copy_en),
    .copy_data  (acc_merged),
    .copy_base  (copy_base),
    .buf_en     (O_buf_en),
    .cnt_buf    (O_cnt_buf),
    .gray       (O_gray),
    .frame_done (O_frame_done),
    .overrun    (O_overrun)
  );

endmodule

// File: tb/tb_zone_max_gray.sv
// Bench for zone_max_gray: a reduced 48x30 frame instance checked through a
// zone-max scoreboard, plus a ZONE_H=1 instance driven hard enough to overrun.
module tb_zone_max_gray;

  localparam int H  = 48;
  localparam int V  = 30;
  localparam int ZC = 24;
  localparam int ZR = 15;
  localparam int ZW = H / ZC;
  localparam int ZH = V / ZR;
  localparam int V2 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       vs = 1'b0, de = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic       buf_en, fd, ov;
  logic [8:0] cnt_buf;
  logic [7:0] gray;

  logic       vs2 = 1'b0, de2 = 1'b0;
  logic [7:0] r2 = '0;
  logic [7:0] zero8 = '0;
  logic       buf_en2, fd2, ov2;
  logic [8:0] cnt2;
  logic [7:0] gray2;

  zone_max_gray #(.H_ACTIVE(H), .V_ACTIVE(V), .ZONE_COLS(ZC), .ZONE_ROWS(ZR)) dut (
    .I_pix_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_de(de),
    .I_data_r(r), .I_data_g(g), .I_data_b(b),
    .O_buf_en(buf_en), .O_cnt_buf(cnt_buf), .O_gray(gray),
    .O_frame_done(fd), .O_overrun(ov)
  );

  zone_max_gray #(.H_ACTIVE(H), .V_ACTIVE(V2), .ZONE_COLS(ZC), .ZONE_ROWS(ZR)) dut_ov (
    .I_pix_clk(clk), .I_rst_n(rst_n), .I_vs(vs2), .I_de(de2),
    .I_data_r(r2), .I_data_g(zero8), .I_data_b(zero8),
    .O_buf_en(buf_en2), .O_cnt_buf(cnt2), .O_gray(gray2),
    .O_frame_done(fd2), .O_overrun(ov2)
  );

  int n_checks = 0, n_pass = 0;
  int n_writes = 0, n_fd = 0, n_ov = 0, n_ov2 = 0, n_fd2 = 0;
  logic [16:0] exp_q[$];
  logic [16:0] e_mon;
  int          wr_log[$];
  logic [7:0]  obs_gray [360];
  logic [7:0]  img_r [V][H];
  logic [7:0]  img_g [V][H];
  logic [7:0]  img_b [V][H];

  // Scoreboard for the main instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fd === 1'b1) n_fd++;
      if (ov === 1'b1) n_ov++;
      if (buf_en === 1'b1) begin
        n_writes++;
        wr_log.push_back(int'(cnt_buf));
        if (cnt_buf < 9'd360) obs_gray[cnt_buf] = gray;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_write: got addr %0d gray 0x%02h, required no write",
                   cnt_buf, gray);
        end else begin
          e_mon = exp_q.pop_front();
          if ({cnt_buf, gray} !== e_mon)
            $display("FAIL sb_write: got addr %0d gray 0x%02h, required addr %0d gray 0x%02h",
                     cnt_buf, gray, e_mon[16:8], e_mon[7:0]);
          else n_pass++;
        end
      end
    end
  end

  // The i-th overrun restarts on band i: base 24*i, line i carries gray i+1.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fd2 === 1'b1) n_fd2++;
      if (ov2 === 1'b1) begin
        n_checks++;
        if (buf_en2 !== 1'b1 || cnt2 !== 9'(24 * (n_ov2 + 1)) || gray2 !== 8'(n_ov2 + 2))
          $display("FAIL overrun_restart: got en %b addr %0d gray %0d, required en 1 addr %0d gray %0d",
                   buf_en2, cnt2, gray2, 24 * (n_ov2 + 1), n_ov2 + 2);
        else n_pass++;
        n_ov2++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        img_r[y][x] = '0;
        img_g[y][x] = '0;
        img_b[y][x] = '0;
      end
  endtask

  task automatic fill_img(input logic [7:0] val, input bit rnd);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        img_r[y][x] = rnd ? 8'($urandom_range(0, 255)) : val;
        img_g[y][x] = rnd ? 8'($urandom_range(0, 255)) : val;
        img_b[y][x] = rnd ? 8'($urandom_range(0, 255)) : val;
      end
  endtask

  // Reference: maximum over every pixel and component of each completed zone.
  task automatic push_expected(input int nlines);
    logic [7:0] m;
    for (int bnd = 0; bnd < nlines / ZH && bnd < ZR; bnd++)
      for (int c = 0; c < ZC; c++) begin
        m = '0;
        for (int yy = bnd * ZH; yy < (bnd + 1) * ZH; yy++)
          for (int xx = c * ZW; xx < (c + 1) * ZW; xx++) begin
            if (img_r[yy][xx] > m) m = img_r[yy][xx];
            if (img_g[yy][xx] > m) m = img_g[yy][xx];
            if (img_b[yy][xx] > m) m = img_b[yy][xx];
          end
        exp_q.push_back({9'(bnd * ZC + c), m});
      end
  endtask

  task automatic drive_frame(input int nlines, input int gap);
    vs = 1'b1;
    repeat (2) tick();
    vs = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < H; x++) begin
        de = 1'b1;
        r = img_r[y][x];
        g = img_g[y][x];
        b = img_b[y][x];
        tick();
      end
      de = 1'b0;
      r = '0;
      g = '0;
      b = '0;
      repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    de = 1'b1;
    r = 8'hFF;
    repeat (3) tick();
    de = 1'b0;
    r = '0;
    n_checks++;
    if (buf_en !== 1'b0) $display("FAIL reset_buf_en: got %b, required 0", buf_en); else n_pass++;
    n_checks++;
    if (cnt_buf !== 9'd0) $display("FAIL reset_cnt_buf: got %0d, required 0", cnt_buf); else n_pass++;
    n_checks++;
    if (gray !== 8'd0) $display("FAIL reset_gray: got %0d, required 0", gray); else n_pass++;
    n_checks++;
    if (fd !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", fd); else n_pass++;
    n_checks++;
    if (ov !== 1'b0) $display("FAIL reset_overrun: got %b, required 0", ov); else n_pass++;
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_flat();
    int w0, f0, o0;
    fill_img(8'h40, 1'b0);
    wr_log.delete();
    w0 = n_writes; f0 = n_fd; o0 = n_ov;
    push_expected(V);
    drive_frame(V, 4);
    repeat (40) tick();
    n_checks++;
    if (n_writes - w0 != 360) $display("FAIL flat_writes: got %0d, required 360", n_writes - w0); else n_pass++;
    n_checks++;
    if (n_fd - f0 != 1) $display("FAIL flat_frame_done: got %0d, required 1", n_fd - f0); else n_pass++;
    n_checks++;
    if (n_ov - o0 != 0) $display("FAIL flat_overrun: got %0d, required 0", n_ov - o0); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL flat_pending: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_checks++;
    if (buf_en !== 1'b0 || cnt_buf !== 9'd359 || gray !== 8'h40)
      $display("FAIL flat_hold: got en %b addr %0d gray 0x%02h, required en 0 addr 359 gray 0x40",
               buf_en, cnt_buf, gray);
    else n_pass++;
  endtask

  task automatic test_single_pixel();
    int nz;
    clear_img();
    img_r[5][3] = 8'hF0;
    push_expected(V);
    drive_frame(V, 4);
    repeat (40) tick();
    nz = 0;
    for (int a = 0; a < 360; a++) if (obs_gray[a] != 8'h00) nz++;
    n_checks++;
    if (obs_gray[49] !== 8'hF0) $display("FAIL single_px_addr49: got 0x%02h, required 0xF0", obs_gray[49]); else n_pass++;
    n_checks++;
    if (nz != 1) $display("FAIL single_px_nonzero: got %0d nonzero zones, required 1", nz); else n_pass++;
  endtask

  task automatic test_zone_boundary();
    clear_img();
    img_g[0][ZW - 1] = 8'hC8;
    img_b[0][ZW]     = 8'hC9;
    push_expected(V);
    drive_frame(V, 4);
    repeat (40) tick();
    n_checks++;
    if (obs_gray[0] !== 8'hC8) $display("FAIL boundary_addr0: got 0x%02h, required 0xC8", obs_gray[0]); else n_pass++;
    n_checks++;
    if (obs_gray[1] !== 8'hC9) $display("FAIL boundary_addr1: got 0x%02h, required 0xC9", obs_gray[1]); else n_pass++;
  endtask

  task automatic test_short_frame();
    int w0, f0;
    fill_img(8'h40, 1'b0);
    w0 = n_writes; f0 = n_fd;
    push_expected(13);
    drive_frame(13, 4);
    repeat (40) tick();
    n_checks++;
    if (n_writes - w0 != 144) $display("FAIL short_writes: got %0d, required 144", n_writes - w0); else n_pass++;
    n_checks++;
    if (n_fd - f0 != 0) $display("FAIL short_frame_done: got %0d, required 0", n_fd - f0); else n_pass++;
    fill_img(8'h00, 1'b1);
    wr_log.delete();
    f0 = n_fd;
    push_expected(V);
    drive_frame(V, 4);
    repeat (40) tick();
    n_checks++;
    if (wr_log.size() == 0 || wr_log[0] != 0)
      $display("FAIL short_next_start: got first addr %0d (writes %0d), required 0",
               wr_log.size() == 0 ? -1 : wr_log[0], wr_log.size());
    else n_pass++;
    n_checks++;
    if (n_fd - f0 != 1) $display("FAIL short_next_frame_done: got %0d, required 1", n_fd - f0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = n_fd;
    fill_img(8'h00, 1'b1);
    push_expected(V);
    drive_frame(V, 2);
    fill_img(8'h00, 1'b1);
    push_expected(V);
    drive_frame(V, 1);
    repeat (40) tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_pending: got %0d left, required 0", exp_q.size()); else n_pass++;
    n_checks++;
    if (n_fd - f0 != 2) $display("FAIL b2b_frame_done: got %0d, required 2", n_fd - f0); else n_pass++;
  endtask

  task automatic test_overrun();
    vs2 = 1'b1;
    repeat (2) tick();
    vs2 = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < V2; y++) begin
      for (int x = 0; x < 4; x++) begin
        de2 = 1'b1;
        r2 = 8'(y + 1);
        tick();
      end
      de2 = 1'b0;
      r2 = '0;
      repeat (10) tick();
    end
    repeat (40) tick();
    n_checks++;
    if (n_ov2 != 14) $display("FAIL overrun_count: got %0d, required 14", n_ov2); else n_pass++;
    n_checks++;
    if (n_fd2 != 1) $display("FAIL overrun_frame_done: got %0d, required 1", n_fd2); else n_pass++;
  endtask

  task automatic test_reset_mid_emission();
    int w0;
    bit found;
    fill_img(8'h40, 1'b0);
    push_expected(V);
    found = 1'b0;
    w0 = 0;
    fork
      drive_frame(V, 4);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (buf_en === 1'b1 && cnt_buf === 9'd10) begin
            found = 1'b1;
            break;
          end
        end
        n_checks++;
        if (!found) begin
          $display("FAIL rst_mid_wait: got no write at k=10 within 2000 cycles, required one");
        end else begin
          n_pass++;
          #1 rst_n = 1'b0;
          #1;
          n_checks++;
          if (buf_en !== 1'b0 || cnt_buf !== 9'd0)
            $display("FAIL rst_mid_abort: got en %b addr %0d, required en 0 addr 0", buf_en, cnt_buf);
          else n_pass++;
          exp_q.delete();
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
        end
        w0 = n_writes;
      end
    join
    repeat (40) tick();
    n_checks++;
    if (n_writes != w0) $display("FAIL rst_mid_quiet: got %0d writes, required 0", n_writes - w0); else n_pass++;
    w0 = n_writes;
    push_expected(V);
    drive_frame(V, 4);
    repeat (40) tick();
    n_checks++;
    if (n_writes - w0 != 360) $display("FAIL rst_mid_recover: got %0d writes, required 360", n_writes - w0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_flat();
    test_single_pixel();
    test_zone_boundary();
    test_short_frame();
    test_back_to_back();
    test_overrun();
    test_reset_mid_emission();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
